// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes and result type shared by the ALU and its arbiter
package alu_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [3:0] {
    ALU_ADDU = 4'b0000,
    ALU_ADD  = 4'b0001,
    ALU_SUBU = 4'b0010,
    ALU_SUB  = 4'b0011,
    ALU_AND  = 4'b0100,
    ALU_OR   = 4'b0101,
    ALU_XOR  = 4'b0110,
    ALU_NOR  = 4'b0111,
    ALU_SLTU = 4'b1000,
    ALU_SLT  = 4'b1001,
    ALU_SLL  = 4'b1100,
    ALU_SRL  = 4'b1101,
    ALU_SRA  = 4'b1110
  } alu_ctl_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              zero;
    logic              ovf;
  } alu_res_t;

endpackage

// File: rtl/alu.sv
// alu: combinational 32-bit integer ALU; overflow only reported for signed ADD/SUB
module alu
  import alu_pkg::*;
(
  input  logic [31:0] ALU_DA,
  input  logic [31:0] ALU_DB,
  input  logic [3:0]  ALU_CTL,
  output logic [31:0] ALU_DC,
  output logic        ALU_ZERO,
  output logic        ALU_OverFlow
);

  logic [31:0] sum;
  logic [31:0] diff;

  assign sum  = ALU_DA + ALU_DB;
  assign diff = ALU_DA - ALU_DB;

  // result select and signed overflow detection; shifts move DA by DB[4:0]
  always_comb begin
    ALU_DC       = '0;
    ALU_OverFlow = 1'b0;
    case (alu_ctl_e'(ALU_CTL))
      ALU_ADDU: ALU_DC = sum;
      ALU_ADD: begin
        ALU_DC       = sum;
        ALU_OverFlow = (ALU_DA[31] == ALU_DB[31]) && (sum[31] != ALU_DA[31]);
      end
      ALU_SUBU: ALU_DC = diff;
      ALU_SUB: begin
        ALU_DC       = diff;
        ALU_OverFlow = (ALU_DA[31] != ALU_DB[31]) && (diff[31] != ALU_DA[31]);
      end
      ALU_AND:  ALU_DC = ALU_DA & ALU_DB;
      ALU_OR:   ALU_DC = ALU_DA | ALU_DB;
      ALU_XOR:  ALU_DC = ALU_DA ^ ALU_DB;
      ALU_NOR:  ALU_DC = ~(ALU_DA | ALU_DB);
      ALU_SLTU: ALU_DC = {31'b0, ALU_DA < ALU_DB};
      ALU_SLT:  ALU_DC = {31'b0, $signed(ALU_DA) < $signed(ALU_DB)};
      ALU_SLL:  ALU_DC = ALU_DA << ALU_DB[4:0];
      ALU_SRL:  ALU_DC = ALU_DA >> ALU_DB[4:0];
      ALU_SRA:  ALU_DC = $signed(ALU_DA) >>> ALU_DB[4:0];
      default:  ALU_DC = '0;
    endcase
  end

  assign ALU_ZERO = (ALU_DC == '0);

endmodule

// File: rtl/alu_rsp_slot.sv
// alu_rsp_slot: single-entry registered response holder with valid/ready handshake
module alu_rsp_slot #(
  parameter type T = logic [31:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic ready,
  input  T     din,
  output logic valid,
  output T     dout
);

  // a load always wins so drain and refill in one cycle leaves the slot full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      dout  <= '0;
    end else begin
      valid <= load || (valid && !ready);
      if (load) dout <= din;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between two requesters with registered responses
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0][31:0]      req_a,
  input  logic [1:0][31:0]      req_b,
  input  logic [1:0][3:0]       req_ctl,
  input  logic [1:0][TAG_W-1:0] req_tag,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [1:0][31:0]      rsp_data,
  output logic [1:0]            rsp_zero,
  output logic [1:0]            rsp_ovf,
  output logic [1:0][TAG_W-1:0] rsp_tag,
  output logic                  ovf_sticky,
  input  logic                  ovf_clr,
  output logic [CNT_W-1:0]      op_cnt
);

  typedef struct packed {
    alu_res_t         res;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  logic [1:0]  slot_free;
  logic [1:0]  eligible;
  logic [1:0]  grant;
  logic        sel;
  logic        any_grant;
  logic        prio;
  logic [31:0] alu_dc;
  logic        alu_zero;
  logic        alu_ovf;
  rsp_t        rsp_in;
  rsp_t        slot_q [2];

  assign slot_free = ~rsp_valid | rsp_ready;
  assign eligible  = req_valid & slot_free;
  assign grant     = (&eligible) ? (prio ? 2'b10 : 2'b01) : eligible;
  assign sel       = grant[1];
  assign any_grant = |grant;
  assign req_ready = grant;

  alu u_alu (
    .ALU_DA      (req_a[sel]),
    .ALU_DB      (req_b[sel]),
    .ALU_CTL     (req_ctl[sel]),
    .ALU_DC      (alu_dc),
    .ALU_ZERO    (alu_zero),
    .ALU_OverFlow(alu_ovf)
  );

  assign rsp_in = {alu_dc, alu_zero, alu_ovf, req_tag[sel]};

  for (genvar i = 0; i < 2; i++) begin : g_slot
    alu_rsp_slot #(.T(rsp_t)) u_slot (
      .clk  (clk),
      .rst_n(rst_n),
      .load (grant[i]),
      .ready(rsp_ready[i]),
      .din  (rsp_in),
      .valid(rsp_valid[i]),
      .dout (slot_q[i])
    );
    assign rsp_data[i] = slot_q[i].res.data;
    assign rsp_zero[i] = slot_q[i].res.zero;
    assign rsp_ovf[i]  = slot_q[i].res.ovf;
    assign rsp_tag[i]  = slot_q[i].tag;
  end

  // priority flips away from the winner; sticky overflow set beats clear; counter wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio       <= 1'b0;
      ovf_sticky <= 1'b0;
      op_cnt     <= '0;
    end else begin
      if (any_grant) prio <= !sel;
      ovf_sticky <= (any_grant && alu_ovf) || (ovf_sticky && !ovf_clr);
      op_cnt     <= op_cnt + {{(CNT_W-1){1'b0}}, any_grant};
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenario tests for the two-port ALU arbiter
module tb_alu_arbiter;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req_valid, req_ready, rsp_valid, rsp_ready, rsp_zero, rsp_ovf;
  logic [1:0][31:0] req_a, req_b, rsp_data;
  logic [1:0][3:0]  req_ctl, req_tag, rsp_tag;
  logic             ovf_sticky, ovf_clr;
  logic [15:0]      op_cnt;
  int               checks = 0;
  int               errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.TAG_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ctl(req_ctl), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf), .rsp_tag(rsp_tag),
    .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr), .op_cnt(op_cnt)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic [3:0] ctl, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] tag);
    req_ctl[p] = ctl;
    req_a[p]   = a;
    req_b[p]   = b;
    req_tag[p] = tag;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 2'b00; rsp_ready = 2'b00; ovf_clr = 1'b0;
    req_a = '0; req_b = '0; req_ctl = '0; req_tag = '0;
    tick();
    tick();
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b exp 00", rsp_valid); end
    checks++; if (rsp_data !== 64'h0) begin errors++; $display("FAIL reset_rsp_data got %h exp 0", rsp_data); end
    checks++; if (op_cnt !== 16'd0 || ovf_sticky !== 1'b0) begin errors++; $display("FAIL reset_cnt_ovf got %0d/%b exp 0/0", op_cnt, ovf_sticky); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b exp 00", req_ready); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_add();
    rsp_ready = 2'b11;
    set_req(0, 4'b0001, 32'h7FFF_FFFF, 32'h0000_0001, 4'd3);
    req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL add_req_ready got %b exp 01", req_ready); end
    tick();
    req_valid = 2'b00;
    #1;
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL add_rsp_valid got %b exp 01", rsp_valid); end
    checks++; if (rsp_data[0] !== 32'h8000_0000) begin errors++; $display("FAIL add_data got %h exp 80000000", rsp_data[0]); end
    checks++; if (rsp_ovf[0] !== 1'b1 || rsp_zero[0] !== 1'b0) begin errors++; $display("FAIL add_flags got ovf=%b zero=%b exp 1/0", rsp_ovf[0], rsp_zero[0]); end
    checks++; if (rsp_tag[0] !== 4'd3) begin errors++; $display("FAIL add_tag got %0d exp 3", rsp_tag[0]); end
    checks++; if (ovf_sticky !== 1'b1 || op_cnt !== 16'd1) begin errors++; $display("FAIL add_sticky_cnt got %b/%0d exp 1/1", ovf_sticky, op_cnt); end
    tick();
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL add_drain got %b exp 00", rsp_valid); end
  endtask

  task automatic test_fairness();
    do_reset();
    rsp_ready = 2'b11;
    set_req(0, 4'b0011, 32'd5, 32'd5, 4'd1);
    set_req(1, 4'b1001, 32'hFFFF_FFFF, 32'd1, 4'd2);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (req_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL fair_grant_%0d got %b exp %b", k, req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      end
      tick();
      checks++;
      if (rsp_valid !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL fair_valid_%0d got %b exp %b", k, rsp_valid, (k % 2 == 0) ? 2'b01 : 2'b10);
      end
    end
    checks++; if (rsp_data[0] !== 32'd0 || rsp_zero[0] !== 1'b1 || rsp_tag[0] !== 4'd1) begin errors++; $display("FAIL fair_p0 got data=%h zero=%b tag=%0d exp 0/1/1", rsp_data[0], rsp_zero[0], rsp_tag[0]); end
    checks++; if (rsp_data[1] !== 32'd1 || rsp_zero[1] !== 1'b0 || rsp_tag[1] !== 4'd2) begin errors++; $display("FAIL fair_p1 got data=%h zero=%b tag=%0d exp 1/0/2", rsp_data[1], rsp_zero[1], rsp_tag[1]); end
    checks++; if (op_cnt !== 16'd4) begin errors++; $display("FAIL fair_cnt got %0d exp 4", op_cnt); end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_stall();
    rsp_ready = 2'b01;
    set_req(1, 4'b0000, 32'd10, 32'd20, 4'd5);
    req_valid = 2'b10;
    tick();
    checks++; if (rsp_valid[1] !== 1'b1 || rsp_data[1] !== 32'd30) begin errors++; $display("FAIL stall_fill got v=%b d=%0d exp 1/30", rsp_valid[1], rsp_data[1]); end
    set_req(1, 4'b0000, 32'd1, 32'd1, 4'd7);
    set_req(0, 4'b0101, 32'h0F, 32'hF0, 4'd6);
    req_valid = 2'b11;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL stall_grant_%0d got %b exp 01", k, req_ready); end
      tick();
      checks++;
      if (rsp_valid !== 2'b11 || rsp_data[1] !== 32'd30 || rsp_tag[1] !== 4'd5 || rsp_data[0] !== 32'hFF) begin
        errors++; $display("FAIL stall_hold_%0d got v=%b d1=%0d t1=%0d d0=%h exp 11/30/5/ff", k, rsp_valid, rsp_data[1], rsp_tag[1], rsp_data[0]);
      end
    end
    rsp_ready = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL stall_release got %b exp 10", req_ready); end
    tick();
    checks++; if (rsp_data[1] !== 32'd2 || rsp_tag[1] !== 4'd7) begin errors++; $display("FAIL stall_new got d=%0d t=%0d exp 2/7", rsp_data[1], rsp_tag[1]); end
    checks++; if (op_cnt !== 16'd9) begin errors++; $display("FAIL stall_cnt got %0d exp 9", op_cnt); end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_back_to_back();
    rsp_ready = 2'b11;
    set_req(0, 4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd9);
    req_valid = 2'b01;
    tick();
    checks++; if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== 32'hF000_F000 || rsp_tag[0] !== 4'd9) begin errors++; $display("FAIL b2b_first got v=%b d=%h t=%0d exp 1/f000f000/9", rsp_valid[0], rsp_data[0], rsp_tag[0]); end
    set_req(0, 4'b0110, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd10);
    tick();
    checks++; if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== 32'h0FF0_0FF0 || rsp_tag[0] !== 4'd10) begin errors++; $display("FAIL b2b_refill got v=%b d=%h t=%0d exp 1/0ff00ff0/10", rsp_valid[0], rsp_data[0], rsp_tag[0]); end
    req_valid = 2'b00;
    tick();
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL b2b_drain got %b exp 00", rsp_valid); end
  endtask

  task automatic test_ovf_clr();
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL ovf_pre got %b exp 0", ovf_sticky); end
    set_req(0, 4'b0001, 32'h7FFF_FFFF, 32'h0000_0001, 4'd4);
    req_valid = 2'b01;
    ovf_clr = 1'b1;
    tick();
    req_valid = 2'b00;
    checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %b exp 1", ovf_sticky); end
    tick();
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", ovf_sticky); end
    ovf_clr = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    rsp_ready = 2'b00;
    set_req(0, 4'b0000, 32'd1, 32'd2, 4'd1);
    set_req(1, 4'b0000, 32'd3, 32'd4, 4'd2);
    req_valid = 2'b11;
    tick();
    tick();
    req_valid = 2'b00;
    #1;
    checks++; if (rsp_valid !== 2'b11 || rsp_data[0] !== 32'd3 || rsp_data[1] !== 32'd7) begin errors++; $display("FAIL arst_fill got v=%b d0=%0d d1=%0d exp 11/3/7", rsp_valid, rsp_data[0], rsp_data[1]); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 2'b00 || rsp_data !== 64'h0 || rsp_tag !== 8'h0) begin errors++; $display("FAIL arst_rsp got v=%b d=%h t=%h exp 0", rsp_valid, rsp_data, rsp_tag); end
    checks++; if (op_cnt !== 16'd0 || ovf_sticky !== 1'b0) begin errors++; $display("FAIL arst_cnt got %0d/%b exp 0/0", op_cnt, ovf_sticky); end
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL arst_first_grant got %b exp 01", req_ready); end
    tick();
    req_valid = 2'b00;
    checks++; if (rsp_valid !== 2'b01 || op_cnt !== 16'd1) begin errors++; $display("FAIL arst_after got v=%b cnt=%0d exp 01/1", rsp_valid, op_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_fairness();
    test_stall();
    test_back_to_back();
    test_ovf_clr();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter sharing the single combinational `alu` instance between two requesters, e.g. the integer EX lane and the address/branch helper. Each port has its own valid/ready request channel and its own registered valid/ready response channel. Arbitration is round-robin. Sticky overflow status and an accepted-operation counter are kept for debug and CSR readout.

## Interface
- `TAG_W`, default 4: width of the opaque requester tag returned with each result.
- `CNT_W`, default 16: width of the accepted-operation counter.

Ports (`i` = 0, 1; per-port signals are packed `[1:0]` or arrays):
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid[i]`  in  1  request present.
- `req_ready[i]`  out  1  request accepted this cycle when high with `req_valid[i]`.
- `req_a[i]`, `req_b[i]`  in  32  operands, driven to `ALU_DA` / `ALU_DB`.
- `req_ctl[i]`  in  4  `ALU_CTL` code.
- `req_tag[i]`  in  `TAG_W`  returned unchanged.
- `rsp_valid[i]`  out  1  result held for port i.
- `rsp_ready[i]`  in  1  consumer takes the result.
- `rsp_data[i]`  out  32  `ALU_DC`.
- `rsp_zero[i]`, `rsp_ovf[i]`  out  1  `ALU_ZERO` and `ALU_OverFlow`.
- `rsp_tag[i]`  out  `TAG_W`  tag of the request.
- `ovf_sticky`  out  1  set by any accepted op with overflow.
- `ovf_clr`  in  1  clears `ovf_sticky`.
- `op_cnt`  out  `CNT_W`  total accepted ops.

## Operation
- `slot_free[i]` = `!rsp_valid[i] || rsp_ready[i]`.
- `eligible[i]` = `req_valid[i] && slot_free[i]`.
- Priority pointer `prio`, 1 bit, reset 0:
  - If both ports are eligible, port `prio` is granted.
  - Otherwise the single eligible port is granted.
  - If none is eligible, no grant.
- At most one grant per cycle. `req_ready[i]` = grant[i].
- On grant to port g:
  - The ALU mux selects port g's operands and ctl.
  - ALU outputs and tag are registered into port g's response slot, and `rsp_valid[g]` is set to 1.
  - `prio` becomes `!g`.
- Response slot i with `rsp_valid[i] && rsp_ready[i]` and no new grant to i: `rsp_valid[i]` is cleared.
- Drain and refill in the same cycle: the slot is overwritten and `rsp_valid[i]` stays 1.
- A stalled port (`rsp_ready`=0 with a full slot) never blocks the other port.
- ALU codes are passed through unchanged; the arbiter does not decode them. The only exception is overflow capture, which uses whatever `ALU_OverFlow` reports.
- `ovf_sticky`:
  - Set on a grant whose `ALU_OverFlow`=1.
  - Cleared by `ovf_clr`.
  - If set and clear happen in the same cycle, set wins.
- `op_cnt` increments by 1 per grant and wraps from all-ones to 0.
- Reset values: `rsp_valid`=0, `rsp_data`=0, `rsp_zero`=0, `rsp_ovf`=0, `rsp_tag`=0, `prio`=0, `ovf_sticky`=0, `op_cnt`=0.
- Reset asserted mid-operation discards held results immediately; nothing is replayed.

## Timing
- Latency: request accepted at edge N; response visible after edge N, i.e. in cycle N+1.
- Aggregate throughput is 1 op/cycle; per port it is 1 op/cycle when the other port is idle.
- `req_ready` is combinational from `req_valid[0:1]`, `rsp_valid[i]`, `rsp_ready[i]` and `prio`.
- Requesters must not derive `req_valid` from `req_ready`.
- Requesters hold a request stable until accepted.
- Response fields are stable while `rsp_valid && !rsp_ready`.
- Fairness: with both ports continuously eligible, grants alternate 0,1,0,1.

## Structure
- Shared package `alu_pkg`:
  - `ALU_CTL` codes: `ALU_ADDU`=0000, `ALU_ADD`=0001, `ALU_SUBU`=0010, `ALU_SUB`=0011, `ALU_AND`=0100, `ALU_OR`=0101, `ALU_XOR`=0110, `ALU_NOR`=0111, `ALU_SLTU`=1000, `ALU_SLT`=1001, `ALU_SLL`=1100, `ALU_SRL`=1101, `ALU_SRA`=1110.
  - Response struct: data, zero, ovf, tag.
- One sub-module is natural: `alu_rsp_slot`, a per-port single-entry response register with valid/ready, instantiated twice.
- The existing `alu` is instantiated once.

## Test plan
- Port 0 only, `ADD` 0x7FFFFFFF + 0x00000001, tag 3:
  - Next cycle: `rsp_data[0]`=0x80000000, `rsp_ovf[0]`=1, tag 3.
  - `ovf_sticky`=1 and `op_cnt`=1.
- Both ports valid every cycle, `rsp_ready`=1 on both, `SUB` 5-5 and `SLT` 0xFFFFFFFF vs 1:
  - Grants alternate 0,1,0,1 starting from port 0.
  - Port 0 gets `rsp_data`=0 with `rsp_zero`=1; port 1 gets `rsp_data`=1.
- Port 1 `rsp_ready`=0 with its slot full, both requesting:
  - Port 0 is granted every cycle.
  - Port 1 response stays frozen; `req_ready[1]`=0 until `rsp_ready[1]` rises.
- Same-cycle drain and refill on port 0 (`AND` 0xF0F0F0F0 & 0xFF00FF00 = 0xF000F000):
  - `rsp_valid[0]` stays 1 with no bubble.
- `ovf_clr` in the same cycle as an overflowing `ADD`: `ovf_sticky` stays 1. `ovf_clr` in a later idle cycle clears it.
- `rst_n` low while both slots hold results:
  - All outputs return to reset values asynchronously.
  - After release, the first contested grant goes to port 0.
